// File: rtl/set_assoc_cache_if.sv
// rtl/set_assoc_cache_if.sv - core request/response and word-wide memory port bundle for set_assoc_cache
interface set_assoc_cache_if #(
   parameter int ADDR_WIDTH = 64,
   parameter int DATA_WIDTH = 64
);
   logic                  req_valid;
   logic                  req_ready;
   logic                  req_write;
   logic [ADDR_WIDTH-1:0] req_addr;
   logic [DATA_WIDTH-1:0] req_wdata;
   logic                  resp_valid;
   logic [DATA_WIDTH-1:0] resp_rdata;

   logic                  mem_req_valid;
   logic                  mem_req_ready;
   logic                  mem_req_write;
   logic [ADDR_WIDTH-1:0] mem_req_addr;
   logic [DATA_WIDTH-1:0] mem_wdata;
   logic                  mem_rvalid;
   logic [DATA_WIDTH-1:0] mem_rdata;

   modport slave (
      input  req_valid, req_write, req_addr, req_wdata,
      output req_ready, resp_valid, resp_rdata,
      output mem_req_valid, mem_req_write, mem_req_addr, mem_wdata,
      input  mem_req_ready, mem_rvalid, mem_rdata
   );

   modport master (
      output req_valid, req_write, req_addr, req_wdata,
      input  req_ready, resp_valid, resp_rdata,
      input  mem_req_valid, mem_req_write, mem_req_addr, mem_wdata,
      output mem_req_ready, mem_rvalid, mem_rdata
   );
endinterface

// File: rtl/set_assoc_cache.sv
// rtl/set_assoc_cache.sv - N-way set-associative write-back, write-allocate data cache
// One core request in flight; single outstanding word beat on the memory port.
module set_assoc_cache #(
   parameter int ADDR_WIDTH    = 64,
   parameter int DATA_WIDTH    = 64,
   parameter int INDEX_LENGTH  = 6,
   parameter int OFFSET_LENGTH = 2,
   parameter int WAYS          = 2
) (
   input  logic             clk,
   input  logic             reset_n,
   set_assoc_cache_if.slave bus,
   output logic [31:0]      hit_count,
   output logic [31:0]      miss_count
);
   localparam int BYTE_BITS  = $clog2(DATA_WIDTH / 8);
   localparam int TAG_LENGTH = ADDR_WIDTH - INDEX_LENGTH - OFFSET_LENGTH - BYTE_BITS;
   localparam int SETS       = 2 ** INDEX_LENGTH;
   localparam int WORDS      = 2 ** OFFSET_LENGTH;
   localparam int WAY_W      = (WAYS > 1) ? $clog2(WAYS) : 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOOKUP,
      S_WB,
      S_FILL_REQ,
      S_FILL_WAIT,
      S_RESP
   } state_t;

   typedef logic [TAG_LENGTH-1:0]    tag_t;
   typedef logic [INDEX_LENGTH-1:0]  idx_t;
   typedef logic [OFFSET_LENGTH-1:0] word_t;
   typedef logic [WAY_W-1:0]         way_t;
   typedef logic [DATA_WIDTH-1:0]    data_t;

   state_t                state_q, state_d;
   logic                  req_write_q, req_write_d;
   logic [ADDR_WIDTH-1:0] req_addr_q, req_addr_d;
   data_t                 req_wdata_q, req_wdata_d;
   way_t                  victim_q, victim_d;
   word_t                 beat_q, beat_d;
   logic                  refill_q, refill_d;
   data_t                 resp_rdata_q, resp_rdata_d;
   logic [31:0]           hit_count_q, hit_count_d;
   logic [31:0]           miss_count_q, miss_count_d;

   logic [WAYS-1:0]       valid_q [SETS];
   logic [WAYS-1:0]       valid_d [SETS];
   logic [WAYS-1:0]       dirty_q [SETS];
   logic [WAYS-1:0]       dirty_d [SETS];
   way_t                  rr_q    [SETS];
   way_t                  rr_d    [SETS];
   tag_t                  tag_q   [SETS][WAYS];
   tag_t                  tag_d   [SETS][WAYS];
   data_t                 data_q  [SETS][WAYS][WORDS];
   data_t                 data_d  [SETS][WAYS][WORDS];

   tag_t  req_tag;
   idx_t  req_idx;
   word_t req_word;
   logic  unused_byte_bits;

   assign req_tag          = req_addr_q[ADDR_WIDTH-1 -: TAG_LENGTH];
   assign req_idx          = req_addr_q[BYTE_BITS+OFFSET_LENGTH +: INDEX_LENGTH];
   assign req_word         = req_addr_q[BYTE_BITS +: OFFSET_LENGTH];
   assign unused_byte_bits = ^req_addr_q[BYTE_BITS-1:0];

   logic hit;
   way_t hit_way;
   logic all_valid;
   way_t free_way;
   way_t victim_sel;

   // Descending scan leaves the lowest-numbered invalid way in free_way.
   always_comb begin
      hit       = 1'b0;
      hit_way   = '0;
      all_valid = 1'b1;
      free_way  = '0;
      for (int w = WAYS - 1; w >= 0; w--) begin
         if (valid_q[req_idx][w] && (tag_q[req_idx][w] == req_tag)) begin
            hit     = 1'b1;
            hit_way = way_t'(w);
         end
         if (!valid_q[req_idx][w]) begin
            all_valid = 1'b0;
            free_way  = way_t'(w);
         end
      end
   end

   assign victim_sel = all_valid ? rr_q[req_idx] : free_way;

   always_comb begin
      state_d      = state_q;
      req_write_d  = req_write_q;
      req_addr_d   = req_addr_q;
      req_wdata_d  = req_wdata_q;
      victim_d     = victim_q;
      beat_d       = beat_q;
      refill_d     = refill_q;
      resp_rdata_d = resp_rdata_q;
      hit_count_d  = hit_count_q;
      miss_count_d = miss_count_q;
      valid_d      = valid_q;
      dirty_d      = dirty_q;
      rr_d         = rr_q;
      tag_d        = tag_q;
      data_d       = data_q;

      unique case (state_q)
         S_IDLE: begin
            if (bus.req_valid) begin
               req_write_d = bus.req_write;
               req_addr_d  = bus.req_addr;
               req_wdata_d = bus.req_wdata;
               state_d     = S_LOOKUP;
            end
         end
         S_LOOKUP: begin
            if (hit) begin
               if (req_write_q) begin
                  data_d[req_idx][hit_way][req_word] = req_wdata_q;
                  dirty_d[req_idx][hit_way]          = 1'b1;
                  resp_rdata_d                       = req_wdata_q;
               end else begin
                  resp_rdata_d = data_q[req_idx][hit_way][req_word];
               end
               if (!refill_q) begin
                  hit_count_d = hit_count_q + 32'd1;
               end
               refill_d = 1'b0;
               state_d  = S_RESP;
            end else begin
               miss_count_d = miss_count_q + 32'd1;
               victim_d     = victim_sel;
               beat_d       = '0;
               if (all_valid) begin
                  rr_d[req_idx] = (rr_q[req_idx] == way_t'(WAYS - 1)) ? '0 : rr_q[req_idx] + 1'b1;
               end
               // The victim is invalid until its refill completes; its tag and data stay readable for writeback.
               valid_d[req_idx][victim_sel] = 1'b0;
               dirty_d[req_idx][victim_sel] = 1'b0;
               state_d = dirty_q[req_idx][victim_sel] ? S_WB : S_FILL_REQ;
            end
         end
         S_WB: begin
            if (bus.mem_req_ready) begin
               if (beat_q == word_t'(WORDS - 1)) begin
                  beat_d  = '0;
                  state_d = S_FILL_REQ;
               end else begin
                  beat_d = beat_q + 1'b1;
               end
            end
         end
         S_FILL_REQ: begin
            if (bus.mem_req_ready) begin
               state_d = S_FILL_WAIT;
            end
         end
         S_FILL_WAIT: begin
            if (bus.mem_rvalid) begin
               data_d[req_idx][victim_q][beat_q] = bus.mem_rdata;
               if (beat_q == word_t'(WORDS - 1)) begin
                  tag_d[req_idx][victim_q]   = req_tag;
                  valid_d[req_idx][victim_q] = 1'b1;
                  dirty_d[req_idx][victim_q] = 1'b0;
                  refill_d                   = 1'b1;
                  state_d                    = S_LOOKUP;
               end else begin
                  beat_d  = beat_q + 1'b1;
                  state_d = S_FILL_REQ;
               end
            end
         end
         S_RESP: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_comb begin
      bus.req_ready     = reset_n && (state_q == S_IDLE);
      bus.resp_valid    = (state_q == S_RESP);
      bus.resp_rdata    = (state_q == S_RESP) ? resp_rdata_q : '0;
      bus.mem_req_valid = 1'b0;
      bus.mem_req_write = 1'b0;
      bus.mem_req_addr  = '0;
      bus.mem_wdata     = '0;
      if (state_q == S_WB) begin
         bus.mem_req_valid = 1'b1;
         bus.mem_req_write = 1'b1;
         bus.mem_req_addr  = {tag_q[req_idx][victim_q], req_idx, beat_q, {BYTE_BITS{1'b0}}};
         bus.mem_wdata     = data_q[req_idx][victim_q][beat_q];
      end else if (state_q == S_FILL_REQ) begin
         bus.mem_req_valid = 1'b1;
         bus.mem_req_addr  = {req_tag, req_idx, beat_q, {BYTE_BITS{1'b0}}};
      end
   end

   assign hit_count  = hit_count_q;
   assign miss_count = miss_count_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= S_IDLE;
         req_write_q  <= 1'b0;
         req_addr_q   <= '0;
         req_wdata_q  <= '0;
         victim_q     <= '0;
         beat_q       <= '0;
         refill_q     <= 1'b0;
         resp_rdata_q <= '0;
         hit_count_q  <= '0;
         miss_count_q <= '0;
         valid_q      <= '{default: '0};
         dirty_q      <= '{default: '0};
         rr_q         <= '{default: '0};
      end else begin
         state_q      <= state_d;
         req_write_q  <= req_write_d;
         req_addr_q   <= req_addr_d;
         req_wdata_q  <= req_wdata_d;
         victim_q     <= victim_d;
         beat_q       <= beat_d;
         refill_q     <= refill_d;
         resp_rdata_q <= resp_rdata_d;
         hit_count_q  <= hit_count_d;
         miss_count_q <= miss_count_d;
         valid_q      <= valid_d;
         dirty_q      <= dirty_d;
         rr_q         <= rr_d;
      end
   end

   always_ff @(posedge clk) begin
      tag_q  <= tag_d;
      data_q <= data_d;
   end
endmodule

// File: tb/tb_set_assoc_cache.sv
// tb/tb_set_assoc_cache.sv - self-checking bench for set_assoc_cache against a flat-memory reference
module tb_set_assoc_cache;
   localparam int AW   = 32;
   localparam int DW   = 64;
   localparam int IL   = 2;
   localparam int OL   = 2;
   localparam int WAYS = 2;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   set_assoc_cache_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();
   logic [31:0] hit_count;
   logic [31:0] miss_count;

   set_assoc_cache #(
      .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .INDEX_LENGTH(IL), .OFFSET_LENGTH(OL), .WAYS(WAYS)
   ) dut (
      .clk(clk), .reset_n(reset_n), .bus(bus), .hit_count(hit_count), .miss_count(miss_count)
   );

   int vectors = 0;
   int errors  = 0;

   typedef struct packed {
      logic        wr;
      logic [31:0] addr;
      logic [63:0] data;
   } beat_t;

   beat_t got_beats[$];
   beat_t exp_beats[$];

   logic [63:0] bmem [logic [31:0]];
   logic [63:0] fmem [logic [31:0]];

   bit          m_valid [4][WAYS];
   bit          m_dirty [4][WAYS];
   logic [24:0] m_tag   [4][WAYS];
   int          m_rr    [4];
   int          m_hits;
   int          m_misses;

   int stall_arm = 0;
   int stall_taken = 0;
   int stall_left = 0;
   int spur_req = 0;
   int spur_done = 0;
   int rd_extra = 0;
   bit rd_pending = 0;
   int rd_delay = 0;
   logic [31:0] rd_addr;
   bit hold_chk = 0;
   beat_t held;
   beat_t cur;

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] init_word(input logic [31:0] a);
      return {a ^ 32'h5A5A_0000, ~a};
   endfunction

   function automatic logic [63:0] bread(input logic [31:0] a);
      return bmem.exists(a) ? bmem[a] : init_word(a);
   endfunction

   function automatic logic [63:0] fread(input logic [31:0] a);
      return fmem.exists(a) ? fmem[a] : init_word(a);
   endfunction

   // Memory side: random ready, random read latency, optional forced stall and stray rvalid.
   always @(negedge clk) begin
      if (!reset_n) begin
         rd_pending        = 0;
         hold_chk          = 0;
         stall_left        = 0;
         bus.mem_rvalid    = 1'b0;
         bus.mem_req_ready = 1'b0;
         bus.mem_rdata     = '0;
      end else begin
         bus.mem_rvalid = 1'b0;
         if (spur_req != spur_done) begin
            spur_done      = spur_req;
            bus.mem_rvalid = 1'b1;
            bus.mem_rdata  = 64'hBAD0_BAD0_BAD0_BAD0;
         end else if (rd_pending) begin
            if (rd_delay == 0) begin
               bus.mem_rvalid = 1'b1;
               bus.mem_rdata  = bread(rd_addr);
               rd_pending     = 0;
            end else begin
               rd_delay--;
            end
         end
         cur.wr   = bus.mem_req_write;
         cur.addr = bus.mem_req_addr;
         cur.data = bus.mem_req_write ? bus.mem_wdata : 64'h0;
         if (hold_chk) begin
            check("mem_hold_valid", bus.mem_req_valid, 1);
            check("mem_hold_beat", cur, held);
         end
         if (bus.mem_req_valid) begin
            if (stall_arm != stall_taken && !bus.mem_req_write) begin
               stall_taken = stall_arm;
               stall_left  = 5;
            end
            if (stall_left > 0) begin
               stall_left--;
               bus.mem_req_ready = 1'b0;
               check("stall_req_ready", bus.req_ready, 0);
               check("stall_resp_valid", bus.resp_valid, 0);
            end else begin
               bus.mem_req_ready = ($urandom_range(0, 3) != 0);
            end
            if (bus.mem_req_ready) begin
               got_beats.push_back(cur);
               hold_chk = 0;
               if (cur.wr) begin
                  bmem[cur.addr] = cur.data;
               end else begin
                  rd_pending = 1;
                  rd_delay   = $urandom_range(0, 3) + rd_extra;
                  rd_addr    = cur.addr;
               end
            end else begin
               hold_chk = 1;
               held     = cur;
            end
         end else begin
            hold_chk          = 0;
            bus.mem_req_ready = ($urandom_range(0, 1) == 1);
         end
      end
   end

   task automatic model_reset();
      for (int s = 0; s < 4; s++) begin
         m_rr[s] = 0;
         for (int w = 0; w < WAYS; w++) begin
            m_valid[s][w] = 0;
            m_dirty[s][w] = 0;
         end
      end
      m_hits   = 0;
      m_misses = 0;
      fmem     = bmem;
   endtask

   task automatic model_access(input bit wr, input logic [31:0] addr, input logic [63:0] wd,
                               output bit hit, output logic [63:0] erd);
      logic [1:0]  s;
      logic [24:0] t;
      logic [31:0] wa;
      beat_t       b;
      int          v;
      s   = addr[6:5];
      t   = addr[31:7];
      wa  = {addr[31:3], 3'b000};
      v   = -1;
      hit = 0;
      exp_beats.delete();
      for (int w = 0; w < WAYS; w++) begin
         if (m_valid[s][w] && m_tag[s][w] == t) begin
            hit = 1;
            v   = w;
         end
      end
      if (hit) begin
         m_hits++;
      end else begin
         m_misses++;
         for (int w = WAYS - 1; w >= 0; w--) begin
            if (!m_valid[s][w]) v = w;
         end
         if (v < 0) begin
            v       = m_rr[s];
            m_rr[s] = (m_rr[s] + 1) % WAYS;
         end
         if (m_valid[s][v] && m_dirty[s][v]) begin
            for (int k = 0; k < 4; k++) begin
               b.wr   = 1'b1;
               b.addr = {m_tag[s][v], s, 2'(k), 3'b000};
               b.data = fread(b.addr);
               exp_beats.push_back(b);
            end
         end
         for (int k = 0; k < 4; k++) begin
            b.wr   = 1'b0;
            b.addr = {t, s, 2'(k), 3'b000};
            b.data = 64'h0;
            exp_beats.push_back(b);
         end
         m_valid[s][v] = 1;
         m_dirty[s][v] = 0;
         m_tag[s][v]   = t;
      end
      if (wr) begin
         m_dirty[s][v] = 1;
         fmem[wa]      = wd;
         erd           = wd;
      end else begin
         erd = fread(wa);
      end
   endtask

   task automatic do_req(input bit wr, input logic [31:0] addr, input logic [63:0] wd,
                         output int lat, output logic [63:0] rd, output bit done);
      int cyc;
      cyc = 0;
      while (!bus.req_ready && cyc < 50) begin
         @(posedge clk); #1;
         cyc++;
      end
      bus.req_valid = 1'b1;
      bus.req_write = wr;
      bus.req_addr  = addr;
      bus.req_wdata = wd;
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
      lat = 1;
      while (!bus.resp_valid && lat < 500) begin
         @(posedge clk); #1;
         lat++;
      end
      done = bus.resp_valid;
      rd   = bus.resp_rdata;
      @(posedge clk); #1;
   endtask

   task automatic run_one(input bit wr, input logic [31:0] addr, input logic [63:0] wd,
                          output int lat, output logic [63:0] rd);
      bit          hit;
      bit          done;
      logic [63:0] erd;
      int          base;
      model_access(wr, addr, wd, hit, erd);
      base = got_beats.size();
      do_req(wr, addr, wd, lat, rd, done);
      check("resp_seen", done, 1);
      check("rdata", rd, erd);
      check("hit_count", hit_count, m_hits);
      check("miss_count", miss_count, m_misses);
      check("beat_count", got_beats.size() - base, exp_beats.size());
      for (int i = 0; i < exp_beats.size() && base + i < got_beats.size(); i++) begin
         check("beat_write", got_beats[base+i].wr, exp_beats[i].wr);
         check("beat_addr", got_beats[base+i].addr, exp_beats[i].addr);
         if (exp_beats[i].wr) check("beat_wdata", got_beats[base+i].data, exp_beats[i].data);
      end
      if (hit) check("hit_latency", lat, 2);
      check("resp_one_cycle", bus.resp_valid, 0);
   endtask

   task automatic check_reset_outputs();
      check("rst_req_ready", bus.req_ready, 0);
      check("rst_resp_valid", bus.resp_valid, 0);
      check("rst_resp_rdata", bus.resp_rdata, 0);
      check("rst_mem_valid", bus.mem_req_valid, 0);
      check("rst_mem_write", bus.mem_req_write, 0);
      check("rst_mem_addr", bus.mem_req_addr, 0);
      check("rst_mem_wdata", bus.mem_wdata, 0);
      check("rst_hit_count", hit_count, 0);
      check("rst_miss_count", miss_count, 0);
   endtask

   task automatic apply_reset();
      @(posedge clk); #1;
      reset_n = 1'b0;
      #1;
      check_reset_outputs();
      repeat (3) @(posedge clk);
      #1;
      reset_n = 1'b1;
      model_reset();
      @(posedge clk); #1;
   endtask

   initial begin
      int          lat;
      int          b0;
      int          cyc;
      logic [63:0] rd;
      logic [31:0] a;
      bus.req_valid = 1'b0;
      bus.req_write = 1'b0;
      bus.req_addr  = '0;
      bus.req_wdata = '0;

      bmem[32'h00] = 64'hA0;
      bmem[32'h08] = 64'hA1;
      bmem[32'h10] = 64'hA2;
      bmem[32'h18] = 64'hA3;
      apply_reset();

      b0 = got_beats.size();
      run_one(0, 32'h008, 64'h0, lat, rd);
      check("cold_rdata", rd, 64'hA1);
      check("cold_miss", miss_count, 1);
      check("cold_beats", got_beats.size() - b0, 4);

      b0 = got_beats.size();
      run_one(0, 32'h010, 64'h0, lat, rd);
      check("hit_rdata", rd, 64'hA2);
      check("hit_lat", lat, 2);
      check("hit_no_mem", got_beats.size() - b0, 0);
      check("hit_cnt", hit_count, 1);

      run_one(1, 32'h018, 64'hDEAD, lat, rd);
      run_one(0, 32'h080, 64'h0, lat, rd);
      stall_arm++;
      b0 = got_beats.size();
      run_one(0, 32'h100, 64'h0, lat, rd);
      check("evict_beats", got_beats.size() - b0, 8);
      if (got_beats.size() - b0 == 8) begin
         check("evict_wb3_data", got_beats[b0+3].data, 64'hDEAD);
         check("evict_fill0_addr", got_beats[b0+4].addr, 32'h100);
      end
      b0 = got_beats.size();
      run_one(0, 32'h000, 64'h0, lat, rd);
      check("rr_clean_evict", got_beats.size() - b0, 4);
      run_one(0, 32'h118, 64'h0, lat, rd);

      for (int n = 0; n < 200; n++) begin
         a = (32'($urandom_range(0, 5)) << 7) | (32'($urandom_range(0, 3)) << 5) |
             (32'($urandom_range(0, 3)) << 3);
         run_one($urandom_range(0, 4) < 2, a, {$urandom, $urandom}, lat, rd);
      end

      apply_reset();
      rd_extra = 40;
      b0 = got_beats.size();
      bus.req_valid = 1'b1;
      bus.req_write = 1'b0;
      bus.req_addr  = 32'h008;
      bus.req_wdata = '0;
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
      cyc = 0;
      while (got_beats.size() == b0 && cyc < 100) begin
         @(posedge clk); #1;
         cyc++;
      end
      check("fw_first_beat", got_beats.size() - b0, 1);
      @(posedge clk); #1;
      check("fw_mem_idle", bus.mem_req_valid, 0);
      #2;
      reset_n = 1'b0;
      #1;
      check_reset_outputs();
      b0 = got_beats.size();
      repeat (3) @(posedge clk);
      #1;
      check("fw_no_beat_in_reset", got_beats.size() - b0, 0);
      reset_n  = 1'b1;
      rd_extra = 0;
      model_reset();
      @(posedge clk); #1;
      run_one(0, 32'h008, 64'h0, lat, rd);
      check("fw_remiss", miss_count, 1);

      apply_reset();
      spur_req++;
      repeat (3) @(posedge clk);
      #1;
      check("spur_ready", bus.req_ready, 1);
      check("spur_mem_idle", bus.mem_req_valid, 0);
      check("spur_hits", hit_count, 0);
      run_one(0, 32'h000, 64'h0, lat, rd);
      check("spur_miss", miss_count, 1);
      check("spur_no_hit", hit_count, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule
